// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared RV32I execute-stage opcodes, forward selects, EX/MEM record
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              result_src;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_plus4;
  } exmem_t;

  // The reserved select 2'b11 falls back to the register-file value.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] reg_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_cycle_if.sv
// ============================================================================
// Module  : execute_cycle_if
// Brief   : ID/EX inputs, forwarding controls and EX/MEM outputs of execute
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_cycle_if;
  logic        RegWriteE;
  logic        ALU_SrcE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [31:0] ResultW;
  logic [1:0]  ForwardA_E;
  logic [1:0]  ForwardB_E;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  modport master (
    output RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardA_E, ForwardB_E,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
           ForwardA_E, ForwardB_E,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );
endinterface

`default_nettype wire

// File: rtl/execute_cycle_alu.sv
// ============================================================================
// Module  : alu
// Brief   : 32-bit wrap-around ALU (ADD/SUB/AND/OR/SLT) with zero flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
  import riscv_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);

  always_comb begin
    Result = 32'h0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'b0, ($signed(A) < $signed(B))};
      default: Result = 32'h0;
    endcase
  end

  assign Zero = (Result == 32'h0);

endmodule

`default_nettype wire

// File: rtl/execute_cycle.sv
// ============================================================================
// Module  : execute_cycle
// Brief   : RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM reg.
//           Operand forwarding is enabled by defining EXECUTE_FORWARDING_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_cycle
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_cycle_if.slave ex
);

  logic [31:0] w_src_a;
  logic [31:0] w_write_data;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  exmem_t      r_exmem;

`ifdef EXECUTE_FORWARDING_EN
  // FWD_MEM taps the EX/MEM register, so a back-to-back dependency needs no stall.
  assign w_src_a      = fwd_mux(ex.ForwardA_E, ex.RD1_E, ex.ResultW, r_exmem.alu_result);
  assign w_write_data = fwd_mux(ex.ForwardB_E, ex.RD2_E, ex.ResultW, r_exmem.alu_result);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex.ForwardA_E, ex.ForwardB_E, ex.ResultW};
  assign w_src_a      = ex.RD1_E;
  assign w_write_data = ex.RD2_E;
`endif

  assign w_src_b = ex.ALU_SrcE ? ex.Imm_Ext_E : w_write_data;

  alu u_alu (
    .A          (w_src_a),
    .B          (w_src_b),
    .ALUControl (ex.ALUControlE),
    .Result     (w_alu_result),
    .Zero       (w_zero)
  );

  assign ex.PCSrcE    = ex.BranchE & w_zero;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exmem <= '0;
    end else begin
      r_exmem <= '{
        reg_write:  ex.RegWriteE,
        mem_write:  ex.MemWriteE,
        result_src: ex.ResultSrcE,
        rd:         ex.RD_E,
        alu_result: w_alu_result,
        write_data: w_write_data,
        pc_plus4:   ex.PCPlus4E
      };
    end
  end

  assign ex.RegWriteM   = r_exmem.reg_write;
  assign ex.MemWriteM   = r_exmem.mem_write;
  assign ex.ResultSrcM  = r_exmem.result_src;
  assign ex.RD_M        = r_exmem.rd;
  assign ex.ALU_ResultM = r_exmem.alu_result;
  assign ex.WriteDataM  = r_exmem.write_data;
  assign ex.PCPlus4M    = r_exmem.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_execute_cycle.sv
// ============================================================================
// Module  : tb_execute_cycle
// Brief   : Self-checking bench for execute_cycle (vectors, sequences, random)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_cycle;

  logic clk = 1'b0;
  logic rst;

  execute_cycle_if ex ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex)
  );

  always #5 clk = ~clk;

`ifdef EXECUTE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } mstate_t;

  mstate_t     mdl;
  mstate_t     nxt;
  logic        exp_pcsrc;
  logic [31:0] exp_target;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        src;
    logic        br;
    logic [31:0] pce;
    logic [31:0] exp_alu;
    logic        exp_pcsrc;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] w, input logic [31:0] m);
    if (FWD && sel == 2'd1) return w;
    if (FWD && sel == 2'd2) return m;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic predict();
    logic [31:0] a, wd, b, res;
    a   = pick(ex.ForwardA_E, ex.RD1_E, ex.ResultW, mdl.alu);
    wd  = pick(ex.ForwardB_E, ex.RD2_E, ex.ResultW, mdl.alu);
    b   = ex.ALU_SrcE ? ex.Imm_Ext_E : wd;
    res = ref_alu(ex.ALUControlE, a, b);
    exp_pcsrc  = ex.BranchE && (res == 32'd0);
    exp_target = ex.PCE + ex.Imm_Ext_E;
    nxt = '{ex.RegWriteE, ex.MemWriteE, ex.ResultSrcE, ex.RD_E, res, wd, ex.PCPlus4E};
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".RegWriteM"},   {31'b0, ex.RegWriteM},  {31'b0, mdl.rw});
    chk({tag, ".MemWriteM"},   {31'b0, ex.MemWriteM},  {31'b0, mdl.mw});
    chk({tag, ".ResultSrcM"},  {31'b0, ex.ResultSrcM}, {31'b0, mdl.rs});
    chk({tag, ".RD_M"},        {27'b0, ex.RD_M},       {27'b0, mdl.rd});
    chk({tag, ".ALU_ResultM"}, ex.ALU_ResultM,         mdl.alu);
    chk({tag, ".WriteDataM"},  ex.WriteDataM,          mdl.wd);
    chk({tag, ".PCPlus4M"},    ex.PCPlus4M,            mdl.pc4);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".RegWriteM"},   {31'b0, ex.RegWriteM},  32'd0);
    chk({tag, ".MemWriteM"},   {31'b0, ex.MemWriteM},  32'd0);
    chk({tag, ".ResultSrcM"},  {31'b0, ex.ResultSrcM}, 32'd0);
    chk({tag, ".RD_M"},        {27'b0, ex.RD_M},       32'd0);
    chk({tag, ".ALU_ResultM"}, ex.ALU_ResultM,         32'd0);
    chk({tag, ".WriteDataM"},  ex.WriteDataM,          32'd0);
    chk({tag, ".PCPlus4M"},    ex.PCPlus4M,            32'd0);
  endtask

  // Called shortly after a rising edge with inputs already driven.
  task automatic cycle(input string tag);
    predict();
    #1;
    chk({tag, ".PCSrcE"},    {31'b0, ex.PCSrcE}, {31'b0, exp_pcsrc});
    chk({tag, ".PCTargetE"}, ex.PCTargetE,       exp_target);
    @(posedge clk);
    mdl = nxt;
    #1;
    check_m(tag);
  endtask

  task automatic randomize_inputs();
    ex.RegWriteE   = 1'($urandom);
    ex.ALU_SrcE    = 1'($urandom);
    ex.MemWriteE   = 1'($urandom);
    ex.ResultSrcE  = 1'($urandom);
    ex.BranchE     = 1'($urandom);
    ex.ALUControlE = 3'($urandom_range(0, 7));
    ex.RD1_E       = $urandom;
    ex.RD2_E       = ($urandom_range(0, 3) == 0) ? ex.RD1_E : $urandom;
    ex.Imm_Ext_E   = $urandom;
    ex.RD_E        = 5'($urandom);
    ex.PCE         = $urandom;
    ex.PCPlus4E    = ex.PCE + 32'd4;
    ex.ResultW     = $urandom;
    ex.ForwardA_E  = 2'($urandom_range(0, 3));
    ex.ForwardB_E  = 2'($urandom_range(0, 3));
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic src, input logic br,
                       input logic [31:0] pce);
    ex.RegWriteE   = 1'b1;
    ex.MemWriteE   = 1'b0;
    ex.ResultSrcE  = 1'b1;
    ex.RD_E        = 5'd7;
    ex.ALUControlE = ctl;
    ex.RD1_E       = rd1;
    ex.RD2_E       = rd2;
    ex.Imm_Ext_E   = imm;
    ex.ALU_SrcE    = src;
    ex.BranchE     = br;
    ex.PCE         = pce;
    ex.PCPlus4E    = pce + 32'd4;
    ex.ResultW     = 32'hDEAD_BEEF;
    ex.ForwardA_E  = 2'b00;
    ex.ForwardB_E  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd5,        32'd7,        32'd0,        1'b0, 1'b0, 32'h0,        32'd12,       1'b0, 32'h0};
    vecs[1]  = '{3'd1, 32'd3,        32'd5,        32'd0,        1'b0, 1'b0, 32'h0,        32'hFFFFFFFE, 1'b0, 32'h0};
    vecs[2]  = '{3'd5, 32'd3,        32'd5,        32'd0,        1'b0, 1'b0, 32'h0,        32'd1,        1'b0, 32'h0};
    vecs[3]  = '{3'd5, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0, 32'h0,        32'd1,        1'b0, 32'h0};
    vecs[4]  = '{3'd5, 32'd1,        32'h80000000, 32'd0,        1'b0, 1'b1, 32'h0,        32'd0,        1'b1, 32'h0};
    vecs[5]  = '{3'd2, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b0, 32'h0,        32'hF000,     1'b0, 32'h0};
    vecs[6]  = '{3'd3, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b0, 32'h0,        32'hFFF0,     1'b0, 32'h0};
    vecs[7]  = '{3'd4, 32'd123,      32'd456,      32'd0,        1'b0, 1'b1, 32'h0,        32'd0,        1'b1, 32'h0};
    vecs[8]  = '{3'd1, 32'd9,        32'd9,        32'hFFFFFFF8, 1'b0, 1'b1, 32'h100,      32'd0,        1'b1, 32'hF8};
    vecs[9]  = '{3'd1, 32'd9,        32'd8,        32'hFFFFFFF8, 1'b0, 1'b1, 32'h100,      32'd1,        1'b0, 32'hF8};
    vecs[10] = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'd8,        1'b0, 1'b0, 32'hFFFFFFFC, 32'd0,        1'b0, 32'h4};
    vecs[11] = '{3'd0, 32'd10,       32'd99,       32'd8,        1'b1, 1'b1, 32'h0,        32'd18,       1'b0, 32'h8};
    vecs[12] = '{3'd6, 32'd1,        32'd1,        32'd0,        1'b0, 1'b0, 32'h0,        32'd0,        1'b0, 32'h0};

    // Asynchronous reset with random inputs, before any clock edge.
    rst = 1'b1;
    randomize_inputs();
    #2 rst = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    mdl = '0;
    #1 check_zero("rst_release");

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].rd1, vecs[i].rd2, vecs[i].imm, vecs[i].src, vecs[i].br, vecs[i].pce);
      #1;
      chk($sformatf("vec%0d.PCSrcE", i), {31'b0, ex.PCSrcE}, {31'b0, vecs[i].exp_pcsrc});
      chk($sformatf("vec%0d.PCTargetE", i), ex.PCTargetE, vecs[i].exp_tgt);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.ALU_ResultM", i), ex.ALU_ResultM, vecs[i].exp_alu);
    end

    // Branch compare changing within one cycle.
    drive(3'd1, 32'd9, 32'd9, 32'hFFFFFFF8, 1'b0, 1'b1, 32'h100);
    #1 chk("br_eq.PCSrcE", {31'b0, ex.PCSrcE}, 32'd1);
    chk("br_eq.PCTargetE", ex.PCTargetE, 32'hF8);
    ex.RD2_E = 32'd8;
    #1 chk("br_ne.PCSrcE", {31'b0, ex.PCSrcE}, 32'd0);
    cycle("br_ne");

    // Forwarding sequences; expectations depend on the build option.
    drive(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 32'h40);
    cycle("fwd1");
    chk("fwd1.ALU_ResultM", ex.ALU_ResultM, 32'd3);

    drive(3'd0, 32'd100, 32'd4, 32'd0, 1'b0, 1'b0, 32'h44);
    ex.ForwardA_E = 2'b10;
    cycle("fwd2");
    chk("fwd2.ALU_ResultM", ex.ALU_ResultM, FWD ? 32'd7 : 32'd104);

    drive(3'd0, 32'd20, 32'd55, 32'd8, 1'b1, 1'b0, 32'h48);
    ex.ForwardB_E = 2'b01;
    ex.ResultW    = 32'hAA;
    cycle("fwd3");
    chk("fwd3.ALU_ResultM", ex.ALU_ResultM, 32'd28);
    chk("fwd3.WriteDataM", ex.WriteDataM, FWD ? 32'hAA : 32'd55);

    drive(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 32'h4C);
    ex.ForwardA_E = 2'b01;
    ex.ForwardB_E = 2'b01;
    ex.ResultW    = 32'h10;
    cycle("fwd4");
    chk("fwd4.ALU_ResultM", ex.ALU_ResultM, FWD ? 32'h20 : 32'd3);

    drive(3'd1, 32'd6, 32'd3, 32'd0, 1'b0, 1'b0, 32'h50);
    ex.ForwardA_E = 2'b11;
    ex.ForwardB_E = 2'b11;
    cycle("fwd5");
    chk("fwd5.ALU_ResultM", ex.ALU_ResultM, 32'd3);

    drive(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h54);
    ex.ForwardA_E = 2'b10;
    ex.ForwardB_E = 2'b10;
    cycle("fwd6");
    chk("fwd6.ALU_ResultM", ex.ALU_ResultM, FWD ? 32'd6 : 32'd0);
    chk("fwd6.WriteDataM", ex.WriteDataM, FWD ? 32'd3 : 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      randomize_inputs();
      cycle($sformatf("rnd%0d", n));
    end

    // Reset asserted mid-cycle discards the in-flight EX/MEM contents.
    drive(3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 32'h200);
    cycle("pre_rst");
    chk("pre_rst.ALU_ResultM", ex.ALU_ResultM, 32'd12);
    #2 rst = 1'b0;
    #1 check_zero("mid_rst");
    mdl = '0;
    @(posedge clk);
    #1 check_zero("mid_rst_held");
    @(negedge clk);
    rst = 1'b1;
    #1 check_zero("mid_rst_release");
    drive(3'd3, 32'h0F, 32'hF0, 32'd0, 1'b0, 1'b0, 32'h300);
    cycle("post_rst");
    chk("post_rst.ALU_ResultM", ex.ALU_ResultM, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX register outputs produced by the decode stage, resolves operand forwarding, runs the ALU, and computes the branch decision and target. Its results are registered into the EX/MEM pipeline register that feeds the memory stage.

## Interface

Parameters: none. The datapath is fixed at 32 bits and register addresses at 5 bits.

Clock and reset are fixed: one clock, `rst` asynchronous and active-low.

- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE` in 1 each: control bits from ID/EX.
- `ALUControlE` in 3: ALU operation.
- `RD1_E, RD2_E` in 32 each: register-file read data.
- `Imm_Ext_E` in 32: sign-extended immediate.
- `RD_E` in 5: destination register.
- `PCE, PCPlus4E` in 32 each: instruction PC and PC+4.
- `ResultW` in 32: writeback result, used as a forwarding source.
- `ForwardA_E, ForwardB_E` in 2 each: forwarding selects from the hazard unit.
- `PCSrcE` out 1: branch taken; combinational.
- `PCTargetE` out 32: branch target, PCE + Imm_Ext_E; combinational.
- `RegWriteM, MemWriteM, ResultSrcM` out 1 each: registered control bits.
- `RD_M` out 5: registered destination register.
- `ALU_ResultM` out 32: registered ALU result.
- `WriteDataM` out 32: registered store data, the forwarded B operand before the immediate mux.
- `PCPlus4M` out 32: registered PC+4.

## Operation

- Forward mux A → SrcA_E:
  - 00 selects RD1_E.
  - 01 selects ResultW.
  - 10 selects ALU_ResultM.
  - 11 is reserved and selects RD1_E.
- Forward mux B → WriteData_E uses the same encoding over RD2_E.
- SrcB_E = ALU_SrcE ? Imm_Ext_E : WriteData_E.
- ALU operations, all 32-bit and wrap-around with no overflow flag:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 101 SLT: signed compare; result is 32'h1 or 32'h0.
  - Any other code: result 0.
- Zero = (ALU result == 0).
- PCSrcE = BranchE & Zero, i.e. BEQ semantics.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^32.
- EX/MEM register captures RegWriteE, MemWriteE, ResultSrcE, RD_E, ALU result, WriteData_E and PCPlus4E on every rising edge.
- The block has no stall or flush inputs. Bubbles arrive from decode as all-zero control bits.

## Timing

- ALU, forwarding muxes, PCSrcE and PCTargetE are combinational from E-stage inputs within the same cycle.
- All *M outputs have 1-cycle latency.
- While `rst` is low, every *M output is 0 immediately, with no clock required:
  - RegWriteM, MemWriteM, ResultSrcM = 0
  - RD_M = 5'h0
  - ALU_ResultM, WriteDataM, PCPlus4M = 32'h0
- Reset asserted mid-operation discards the in-flight EX/MEM contents.
- Reset release is sampled at the next rising edge.
- ForwardA_E = 10 reads the current ALU_ResultM, i.e. the previous instruction's result. A back-to-back dependency therefore resolves in zero stall cycles.
- Simultaneous forwarding of both operands, including both from the same source, is legal and independent.
- PCSrcE is not registered. The fetch and decode flush it triggers is the hazard unit's job.

## Configuration

Macro: `EXECUTE_FORWARDING_EN`.

- Defined: the forwarding muxes behave as described in Operation.
- Undefined:
  - ForwardA_E and ForwardB_E are ignored.
  - SrcA_E = RD1_E and WriteData_E = RD2_E.
  - The ports remain in the interface so the top level is unchanged.
  - Software or the hazard unit must insert stalls for data hazards.

## Structure

- Shared package `riscv_pkg`:
  - ALU opcode localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Forward select localparams: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, `alu`: inputs A[31:0], B[31:0] and ALUControl[2:0]; outputs Result[31:0] and Zero.
- The forwarding muxes, branch adder and EX/MEM register live in execute_cycle.

## Test plan

1. Reset low, inputs random → all *M outputs 0. Release reset, then RD1_E=5, RD2_E=7, ADD, ALU_SrcE=0 → next edge: ALU_ResultM=12, WriteDataM=7.
2. SUB, RD1_E=3, RD2_E=5 → ALU_ResultM=32'hFFFF_FFFE.
   - SLT with the same operands → 1.
   - SLT with RD1_E=32'h8000_0000, RD2_E=1 → 1.
3. BranchE=1, SUB, RD1_E=RD2_E=9, PCE=32'h100, Imm_Ext_E=32'hFFFF_FFF8:
   - Same cycle: PCSrcE=1, PCTargetE=32'hF8.
   - Change RD2_E to 8 → PCSrcE=0.
4. Back-to-back forwarding (macro defined):
   - Cycle 1: ADD 1+2 → ALU_ResultM=3.
   - Cycle 2: ForwardA_E=10, RD2_E=4 → ALU_ResultM=7.
   - Then ForwardB_E=01 with ResultW=32'hAA and ALU_SrcE=1, Imm_Ext_E=8 → ALU_ResultM = SrcA+8 and WriteDataM=32'hAA.
5. Same stimulus as scenario 4 with the macro undefined → forwarding ignored; ALU_ResultM = RD1_E + RD2_E.
6. Assert rst asynchronously mid-cycle while ALU_ResultM=12 → all *M outputs go to 0 before the next edge. After release they hold 0 until the first capturing edge.
